// File: rtl/st_threshold_peak_trigger.sv
// Threshold/hysteresis self-trigger with glitch rejection, peak and time-over-threshold capture, and holdoff.
// Define ST_TIMESTAMP_EN to add a free-running sample counter and the ts output.
module st_threshold_peak_trigger #(
   parameter int unsigned HOLDOFF = 64,
   parameter int unsigned MIN_TOT = 2,
   parameter int unsigned TOT_W   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic signed [15:0]      x,
   input  logic signed [15:0]      threshold,
   input  logic        [14:0]      hysteresis,
   output logic                    trigger,
   output logic signed [15:0]      peak,
   output logic        [TOT_W-1:0] tot,
   output logic                    busy
`ifdef ST_TIMESTAMP_EN
   ,
   output logic        [31:0]      ts
`endif
);

   typedef enum logic [1:0] {S_ARMED, S_ABOVE, S_HOLD, S_REARM} state_t;

   logic               reset_q, enable_q, s_valid_q;
   logic signed [15:0] in_q;

   state_t             state_q, state_d;
   logic signed [15:0] pk_q, pk_d, peak_q, peak_d;
   logic [TOT_W-1:0]   cnt_q, cnt_d, tot_q, tot_d;
   logic [15:0]        hcnt_q, hcnt_d;
   logic               trigger_q, trigger_d;

   logic signed [16:0] sample, thr, exit_level;

   // NOTE: reset is applied through reset_q, so it takes effect one edge after the pin.
   always_ff @(posedge clk) begin
      reset_q  <= reset;
      enable_q <= enable;
      if (reset_q) begin
         s_valid_q <= 1'b0;
         in_q      <= '0;
      end else begin
         s_valid_q <= enable_q;
         if (enable_q) in_q <= x;
      end
   end

   assign sample     = {in_q[15], in_q};
   assign thr        = {threshold[15], threshold};
   assign exit_level = thr - $signed({2'b00, hysteresis});

   // NOTE: every next-state value defaults to its current value so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      pk_d      = pk_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      peak_d    = peak_q;
      tot_d     = tot_q;
      trigger_d = 1'b0;
      if (s_valid_q) begin
         unique case (state_q)
            S_ARMED: begin
               if (sample > thr) begin
                  state_d = S_ABOVE;
                  pk_d    = in_q;
                  cnt_d   = TOT_W'(1);
               end
            end
            S_ABOVE: begin
               // The exiting sample never contributes to pk or cnt.
               if (sample < exit_level) begin
                  if (32'(cnt_q) >= MIN_TOT) begin
                     trigger_d = 1'b1;
                     peak_d    = pk_q;
                     tot_d     = cnt_q;
                     hcnt_d    = '0;
                     state_d   = S_HOLD;
                  end else begin
                     state_d = S_ARMED;
                  end
               end else begin
                  if (in_q > pk_q) pk_d = in_q;
                  if (cnt_q != '1) cnt_d = cnt_q + TOT_W'(1);
               end
            end
            S_HOLD: begin
               if (hcnt_q == 16'(HOLDOFF - 1)) begin
                  state_d = (sample < exit_level) ? S_ARMED : S_REARM;
               end else begin
                  hcnt_d = hcnt_q + 16'd1;
               end
            end
            S_REARM: begin
               if (sample < exit_level) state_d = S_ARMED;
            end
            default: state_d = S_ARMED;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset_q) begin
         state_q   <= S_ARMED;
         pk_q      <= '0;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         peak_q    <= '0;
         tot_q     <= '0;
         trigger_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pk_q      <= pk_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         peak_q    <= peak_d;
         tot_q     <= tot_d;
         trigger_q <= trigger_d;
      end
   end

   assign trigger = trigger_q;
   assign peak    = peak_q;
   assign tot     = tot_q;
   assign busy    = (state_q != S_ARMED);

`ifdef ST_TIMESTAMP_EN
   logic [31:0] ts_cnt_q, ts_start_q, ts_q;

   // The start stamp is taken on the sample that moves ARMED to ABOVE; glitches never reach ts_q.
   always_ff @(posedge clk) begin
      if (reset_q) begin
         ts_cnt_q   <= '0;
         ts_start_q <= '0;
         ts_q       <= '0;
      end else if (s_valid_q) begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         if (state_q == S_ARMED && state_d == S_ABOVE) ts_start_q <= ts_cnt_q;
         if (trigger_d) ts_q <= ts_start_q;
      end
   end

   assign ts = ts_q;
`endif

endmodule

// File: tb/tb_st_threshold_peak_trigger.sv
// Scoreboard bench for st_threshold_peak_trigger: a behavioural model queues the expected outputs
// for each driven cycle, and they are popped and compared once the two-edge latency has elapsed.
module tb_st_threshold_peak_trigger;

   localparam int unsigned HOLDOFF = 4;
   localparam int unsigned MIN_TOT = 2;
   localparam int unsigned TOT_W   = 8;
   localparam int          TH      = 8300;
   localparam int          HY      = 20;

   logic               clk;
   logic               reset;
   logic               enable;
   logic signed [15:0] x;
   logic signed [15:0] threshold;
   logic        [14:0] hysteresis;
   logic               trigger;
   logic signed [15:0] peak;
   logic [TOT_W-1:0]   tot;
   logic               busy;
   logic [31:0]        ts;

   st_threshold_peak_trigger #(
      .HOLDOFF(HOLDOFF),
      .MIN_TOT(MIN_TOT),
      .TOT_W  (TOT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .x         (x),
      .threshold (threshold),
      .hysteresis(hysteresis),
      .trigger   (trigger),
      .peak      (peak),
      .tot       (tot),
      .busy      (busy)
`ifdef ST_TIMESTAMP_EN
      ,
      .ts        (ts)
`endif
   );

`ifndef ST_TIMESTAMP_EN
   assign ts = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {M_ARMED, M_ABOVE, M_HOLD, M_REARM} mstate_t;

   typedef struct packed {
      logic        trig;
      logic        busy;
      logic [15:0] peak;
      logic [7:0]  tot;
      logic [31:0] ts;
   } exp_t;

   exp_t    sb[$];
   int      n_tests = 0;
   int      n_fail  = 0;

   mstate_t m_state;
   int      m_pk, m_cnt, m_h, m_peak, m_tot;
   logic [31:0] m_tsc, m_tss, m_ts;
   logic    m_trig;
   bit      prev_en, prev_rst;

   int      trig_seen;
   int      last_peak, last_tot;

   task automatic model_reset();
      m_state = M_ARMED;
      m_pk = 0; m_cnt = 0; m_h = 0; m_peak = 0; m_tot = 0;
      m_tsc = '0; m_tss = '0; m_ts = '0; m_trig = 1'b0;
   endtask

   task automatic model_step(input int s);
      int lvl;
      lvl = TH - HY;
      case (m_state)
         M_ARMED: if (s > TH) begin
            m_state = M_ABOVE; m_pk = s; m_cnt = 1; m_tss = m_tsc;
         end
         M_ABOVE: if (s < lvl) begin
            if (m_cnt >= int'(MIN_TOT)) begin
               m_trig = 1'b1; m_peak = m_pk; m_tot = m_cnt; m_ts = m_tss;
               m_state = M_HOLD; m_h = 0;
            end else m_state = M_ARMED;
         end else begin
            if (s > m_pk) m_pk = s;
            if (m_cnt < 255) m_cnt++;
         end
         M_HOLD: if (m_h == int'(HOLDOFF) - 1) m_state = (s < lvl) ? M_ARMED : M_REARM;
                 else m_h++;
         M_REARM: if (s < lvl) m_state = M_ARMED;
         default: m_state = M_ARMED;
      endcase
      m_tsc = m_tsc + 32'd1;
   endtask

   task automatic compare(input exp_t e);
      n_tests++;
      assert (trigger === e.trig) else begin
         n_fail++; $error("FAIL trigger: observed %0b expected %0b", trigger, e.trig);
      end
      n_tests++;
      assert (busy === e.busy) else begin
         n_fail++; $error("FAIL busy: observed %0b expected %0b", busy, e.busy);
      end
      n_tests++;
      assert (peak === e.peak) else begin
         n_fail++; $error("FAIL peak: observed %0d expected %0d", peak, $signed(e.peak));
      end
      n_tests++;
      assert (tot === e.tot) else begin
         n_fail++; $error("FAIL tot: observed %0d expected %0d", tot, e.tot);
      end
`ifdef ST_TIMESTAMP_EN
      n_tests++;
      assert (ts === e.ts) else begin
         n_fail++; $error("FAIL ts: observed %0d expected %0d", ts, e.ts);
      end
`endif
      if (trigger === 1'b1) begin
         trig_seen++;
         last_peak = int'(peak);
         last_tot  = int'(tot);
      end
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      n_tests++;
      assert (observed === expected) else begin
         n_fail++; $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One cycle: drive inputs, queue the model's output due two edges later, compare what is due now.
   task automatic drive(input bit r, input bit e, input int xv);
      exp_t nx;
      reset  = r;
      enable = e;
      x      = xv[15:0];
      if (r) model_reset();
      else begin
         m_trig = 1'b0;
         if (prev_en && !prev_rst) model_step(xv);
      end
      nx.trig = m_trig;
      nx.busy = (m_state != M_ARMED);
      nx.peak = m_peak[15:0];
      nx.tot  = m_tot[7:0];
      nx.ts   = m_ts;
      sb.push_back(nx);
      prev_en  = e;
      prev_rst = r;
      @(posedge clk);
      #1;
      compare(sb.pop_front());
   endtask

   task automatic run(input int xv, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, xv);
   endtask

   initial begin
      exp_t rst_e;
      threshold  = 16'(TH);
      hysteresis = 15'(HY);
      reset      = 1'b1;
      enable     = 1'b0;
      x          = 16'sd8192;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      prev_en  = 1'b0;
      prev_rst = 1'b1;
      rst_e    = '0;
      sb.push_back(rst_e);

      // Baseline only.
      trig_seen = 0;
      run(8192, 200);
      check("baseline_triggers", trig_seen, 0);
      check("baseline_busy", int'(busy), 0);

      // Single pulse: exit on 8250, which is below the 8280 exit level.
      trig_seen = 0;
      run(8192, 1); run(8400, 1); run(8600, 1); run(8500, 1);
      drive(1'b0, 1'b1, 8250);
      drive(1'b0, 1'b1, 8100);
      check("pulse_on_second_edge", int'(trigger), 1);
      run(8192, 8);
      check("pulse_count", trig_seen, 1);
      check("pulse_peak", last_peak, 8600);
      check("pulse_tot", last_tot, 3);

      // Glitch: a single sample over threshold.
      trig_seen = 0;
      run(8400, 1); run(8192, 4);
      check("glitch_count", trig_seen, 0);
      check("glitch_peak_held", int'(peak), 8600);
      check("glitch_tot_held", int'(tot), 3);

      // Holdoff then REARM: the second pulse straddles holdoff end and is ignored.
      trig_seen = 0;
      run(8400, 1); run(8500, 1); run(8100, 1);
      run(8192, 1); run(8400, 6);
      check("rearm_busy", int'(busy), 1);
      run(8192, 1); run(8400, 1); run(8450, 1); run(8100, 1);
      run(8192, 8);
      check("rearm_count", trig_seen, 2);
      check("rearm_peak", last_peak, 8450);
      check("rearm_tot", last_tot, 2);

      // Enable gating mid-event: the 8100 samples while disabled must not end it.
      trig_seen = 0;
      run(8400, 1); run(8500, 1);
      drive(1'b0, 1'b0, 8500);
      for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 8100);
      drive(1'b0, 1'b1, 8100);
      run(8600, 1); run(8100, 1);
      run(8192, 8);
      check("gate_count", trig_seen, 1);
      check("gate_peak", last_peak, 8600);
      check("gate_tot", last_tot, 4);

      // Reset while in ABOVE aborts the event.
      trig_seen = 0;
      run(8400, 1); run(8500, 1);
      drive(1'b1, 1'b1, 8100);
      drive(1'b0, 1'b1, 8100);
      check("reset_peak", int'(peak), 0);
      check("reset_tot", int'(tot), 0);
      check("reset_busy", int'(busy), 0);
      run(8192, 6);
      check("reset_count", trig_seen, 0);

      // Saturation of the time-over-threshold counter.
      trig_seen = 0;
      run(9000, 300); run(8100, 1);
      run(8192, 8);
      check("sat_count", trig_seen, 1);
      check("sat_peak", last_peak, 9000);
      check("sat_tot", last_tot, 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
